// File: rtl/prescaler_ctrl_pkg.sv
// prescaler_ctrl_pkg
//   Shared constants and helpers for the prescaler controller.
//   - NCH_DEF / DIV_W_DEF / CNT_W_DEF : default parameter values
//   - CNT_W_MAX                       : widest supported prescale counter
//   - limit_mask()                    : div_val -> terminal-count mask
package prescaler_ctrl_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DIV_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int CNT_W_MAX = 16;

    // Terminal count for a divider select: 2^div_val - 1, saturating to
    // all-ones of the counter width when div_val reaches cnt_w.
    // Bits at or above cnt_w are always zero.
    function automatic logic [CNT_W_MAX-1:0] limit_mask(input int div_val,
                                                        input int cnt_w);
        logic [CNT_W_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < CNT_W_MAX; i++) begin
            m[i] = (i < div_val) && (i < cnt_w);
        end
        return m;
    endfunction

endpackage

// File: rtl/prescaler_ctrl_ch.sv
// prescaler_ch
//   Single prescaler channel: prescale counter, limit decode and the
//   cnt_en / cnt_clr strobes for one timer.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     tim_en     : timer enable
//     div_en     : divider enable
//     div_val    : divider select (period 2^div_val)
//     sync_clr   : restart the prescale counter (works even while halted)
//     halt       : registered halt acknowledge from the top; freezes counting
//     cnt_en     : counter-increment strobe
//     cnt_clr    : counter-clear strobe, first cycle after tim_en falls
module prescaler_ch
    import prescaler_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tim_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             sync_clr,
    input  logic             halt,
    output logic             cnt_en,
    output logic             cnt_clr
);

    logic [CNT_W-1:0]     cnt;
    logic [DIV_W-1:0]     div_val_q;
    logic                 tim_en_q;
    logic [CNT_W_MAX-1:0] lim;
    logic                 at_lim;
    logic                 restart;

    assign lim = limit_mask(int'(div_val), CNT_W);

    // lim has zeros above CNT_W, so a zero-extended compare is exact.
    assign at_lim  = (CNT_W_MAX'(cnt) == lim);

    // The limit comes from the live div_val, so a mid-period change only
    // pulses if the old count already equals the new limit.
    assign restart = ~tim_en | ~div_en | (div_val != div_val_q) | at_lim;

    assign cnt_en  = ~halt & tim_en & (~div_en | (div_val == '0) | at_lim);
    assign cnt_clr = tim_en_q & ~tim_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            div_val_q <= '0;
            tim_en_q  <= 1'b0;
        end else begin
            tim_en_q  <= tim_en;
            div_val_q <= div_val;
            if (sync_clr) begin
                cnt <= '0;
            end else if (!halt) begin
                if (restart) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl
//   NCH independent timer prescalers with a shared restart (sync_clr) and a
//   shared debugger halt.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     tim_en     : per-channel timer enable           [NCH]
//     div_en     : per-channel divider enable         [NCH]
//     div_val    : per-channel divider select         [NCH*DIV_W]
//     sync_clr   : single-cycle restart of all prescale counters
//     halt_req   : debugger halt request
//     debug_mode : debug mode active
//     halt_ack   : registered halt acknowledge
//     cnt_en     : per-channel counter-increment strobe [NCH]
//     cnt_clr    : per-channel counter-clear strobe     [NCH]
//   Build option: PRESCALER_CTRL_DBG_HALT_EN enables the debugger halt.
//   Without it halt_ack is 0 and halt_req/debug_mode are ignored.
module prescaler_ctrl
    import prescaler_ctrl_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       tim_en,
    input  logic [NCH-1:0]       div_en,
    input  logic [NCH*DIV_W-1:0] div_val,
    input  logic                 sync_clr,
    input  logic                 halt_req,
    input  logic                 debug_mode,
    output logic                 halt_ack,
    output logic [NCH-1:0]       cnt_en,
    output logic [NCH-1:0]       cnt_clr
);

`ifdef PRESCALER_CTRL_DBG_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_ack <= 1'b0;
        end else begin
            halt_ack <= halt_req & debug_mode;
        end
    end
`else
    logic halt_unused;
    assign halt_unused = halt_req ^ debug_mode;
    assign halt_ack    = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        prescaler_ch #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tim_en   (tim_en[i]),
            .div_en   (div_en[i]),
            .div_val  (div_val[i*DIV_W +: DIV_W]),
            .sync_clr (sync_clr),
            .halt     (halt_ack),
            .cnt_en   (cnt_en[i]),
            .cnt_clr  (cnt_clr[i])
        );
    end

endmodule

// File: tb/tb_prescaler_ctrl.sv
module tb_prescaler_ctrl;

    localparam int NCH   = 4;
    localparam int DIV_W = 4;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       tim_en;
    logic [NCH-1:0]       div_en;
    logic [NCH*DIV_W-1:0] div_val;
    logic                 sync_clr;
    logic                 halt_req;
    logic                 debug_mode;
    logic                 halt_ack;
    logic [NCH-1:0]       cnt_en;
    logic [NCH-1:0]       cnt_clr;

    prescaler_ctrl #(.NCH(NCH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tim_en     (tim_en),
        .div_en     (div_en),
        .div_val    (div_val),
        .sync_clr   (sync_clr),
        .halt_req   (halt_req),
        .debug_mode (debug_mode),
        .halt_ack   (halt_ack),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles elapsed in the current prescale period,
    // previous-cycle tim_en / div_val per channel, and the halt flag.
    int phase [NCH];
    int dv_prev [NCH];
    bit te_prev [NCH];
    bit halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Prescale period in cycles: 2^div_val, capped at the counter range.
    function automatic int period(input int dv);
        return (dv >= CNT_W) ? (1 << CNT_W) : (1 << dv);
    endfunction

    function automatic int get_dv(input int ch);
        logic [DIV_W-1:0] f;
        f = div_val[ch*DIV_W +: DIV_W];
        return int'(f);
    endfunction

    task automatic set_ch(input int ch, input bit te, input bit de, input int dv);
        tim_en[ch] = te;
        div_en[ch] = de;
        div_val[ch*DIV_W +: DIV_W] = DIV_W'(dv);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            phase[i]   = 0;
            dv_prev[i] = 0;
            te_prev[i] = 0;
        end
        halted = 0;
    endtask

    // Called just after the falling edge with inputs already applied:
    // check outputs, then advance the model across the next rising edge.
    task automatic cycle();
        logic [NCH-1:0] exp_en;
        logic [NCH-1:0] exp_clr;
        int  nph [NCH];
        bit  nhalt;
        #1;
        for (int i = 0; i < NCH; i++) begin
            bit te, de;
            int dv, p;
            bit last;
            te   = tim_en[i];
            de   = div_en[i];
            dv   = get_dv(i);
            p    = period(dv);
            last = (phase[i] == p - 1);
            exp_en[i]  = !halted && te && (!de || dv == 0 || last);
            exp_clr[i] = te_prev[i] && !te;
            if (sync_clr)
                nph[i] = 0;
            else if (halted)
                nph[i] = phase[i];
            else if (!te || !de || dv != dv_prev[i] || last)
                nph[i] = 0;
            else
                nph[i] = phase[i] + 1;
        end
`ifdef PRESCALER_CTRL_DBG_HALT_EN
        nhalt = halt_req && debug_mode;
`else
        nhalt = 0;
`endif
        check("cnt_en", 32'(cnt_en), 32'(exp_en));
        check("cnt_clr", 32'(cnt_clr), 32'(exp_clr));
        check("halt_ack", 32'(halt_ack), 32'(halted));
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            phase[i]   = nph[i];
            te_prev[i] = tim_en[i];
            dv_prev[i] = get_dv(i);
        end
        halted = nhalt;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        tim_en     = '0;
        div_en     = '0;
        div_val    = '0;
        sync_clr   = 1'b0;
        halt_req   = 1'b0;
        debug_mode = 1'b0;
        rst_n      = 1'b0;
        model_clear();
        #2;
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rst_halt_ack", 32'(halt_ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // ch0 divide by 4, then by 256 (select beyond counter width)
        set_ch(0, 1, 1, 2);
        run(20);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            pulses += int'(cnt_en[0]);
            cycle();
        end
        check("div4_pulses", 32'(pulses), 32'd4);
        set_ch(0, 1, 1, 9);
        run(520);

        // ch1 undivided: divider off, then div_val 0
        set_ch(1, 1, 0, 5);
        run(8);
        set_ch(1, 1, 1, 0);
        run(8);

        // halt while ch0 runs divide-by-8
        set_ch(0, 1, 1, 3);
        run(13);
        halt_req   = 1'b1;
        debug_mode = 1'b1;
        run(10);
        halt_req   = 1'b0;
        run(12);

        // ch2 disable / re-enable
        set_ch(2, 1, 1, 2);
        run(6);
        set_ch(2, 0, 1, 2);
        run(3);
        set_ch(2, 1, 1, 2);
        run(10);

        // sync_clr with ch0 /16 and ch1 /4 out of phase
        set_ch(0, 1, 1, 4);
        set_ch(1, 1, 1, 2);
        run(7);
        sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        run(20);

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(15) == 0) begin
                    int dv;
                    dv = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : int'($urandom_range(4));
                    set_ch(i, ($urandom_range(5) != 0), ($urandom_range(3) != 0), dv);
                end
            end
            sync_clr   = ($urandom_range(31) == 0);
            if ($urandom_range(19) == 0) halt_req = ~halt_req;
            debug_mode = ($urandom_range(7) != 0);
            cycle();
        end
        sync_clr = 1'b0;
        halt_req = 1'b0;

        // reset mid-period, then restart all channels at divide-by-4
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 3);
        run(5);
        do_reset();
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 2);
        run(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
